// File: rtl/mem_blk_arbiter.sv
// Two-port round-robin arbiter in front of the single-port mem_blk RAM.
// One RAM access per cycle; the response returns to the owning port one cycle after grant.
module mem_blk_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_cea_o,
  output logic              mem_wea_o,
  output logic [ADDR_W-1:0] mem_addra_o,
  output logic [DATA_W-1:0] mem_dia_o,
  input  logic [DATA_W-1:0] mem_doa_i
);

  // Handshake: a port's access is taken in the cycle gnt_o[p]=1 (req/we/addr/wdata
  // sampled only then); exactly one rvalid_o[p] pulse follows in the next cycle,
  // qualified by err_o, with rdata_o carrying read data (0 for writes and errors).

  logic prio_q, prio_d;
  logic pend_q, pend_d;
  logic own_q, own_d;
  logic rd_q, rd_d;
  logic err_q, err_d;

  logic              sel;
  logic              gnt_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic              resp_ok;

  always_comb begin
    gnt_o = 2'b00;
    sel   = 1'b0;
    if (!rst) begin
      case (req_i)
        2'b01: begin gnt_o = 2'b01; sel = 1'b0; end
        2'b10: begin gnt_o = 2'b10; sel = 1'b1; end
        2'b11: begin
          sel   = prio_q;
          gnt_o = prio_q ? 2'b10 : 2'b01;
        end
        default: begin gnt_o = 2'b00; sel = 1'b0; end
      endcase
    end
    gnt_any = |gnt_o;
  end

  // With no grant sel stays 0, so the RAM address/data buses idle on port-0 values.
  always_comb begin
    sel_addr  = sel ? addr1_i  : addr0_i;
    sel_wdata = sel ? wdata1_i : wdata0_i;
    sel_we    = sel ? we_i[1]  : we_i[0];
    in_range  = (32'(sel_addr) < 32'(DEPTH));

    mem_addra_o = sel_addr;
    mem_dia_o   = sel_wdata;
    mem_cea_o   = gnt_any & in_range;
    mem_wea_o   = gnt_any & in_range & sel_we;
  end

  always_comb begin
    prio_d = gnt_any ? ~sel : prio_q;
    pend_d = gnt_any;
    own_d  = gnt_any ? sel : own_q;
    rd_d   = gnt_any ? ~sel_we : rd_q;
    err_d  = gnt_any ? ~in_range : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      pend_q <= 1'b0;
      own_q  <= 1'b0;
      rd_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      pend_q <= pend_d;
      own_q  <= own_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
    end
  end

  // A response still pending when reset arrives is dropped rather than delivered.
  always_comb begin
    resp_ok  = pend_q & ~rst;
    rvalid_o = resp_ok ? (own_q ? 2'b10 : 2'b01) : 2'b00;
    err_o    = resp_ok & err_q;
    rdata_o  = (resp_ok & rd_q & ~err_q) ? mem_doa_i : '0;
  end

endmodule

// File: tb/tb_mem_blk_arbiter.sv
// Bench for mem_blk_arbiter with a behavioural mem_blk port A model (1-cycle read).
// Directed vectors push expected responses; a negedge monitor pops and compares them.
module tb_mem_blk_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 200;
  localparam int W      = 16 + 2 + 1 + DATA_W;

  logic              clk;
  logic              rst;
  logic [1:0]        req_i;
  logic [1:0]        we_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata0_i;
  logic [DATA_W-1:0] wdata1_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic              err_o;
  logic [DATA_W-1:0] rdata_o;
  logic              mem_cea_o;
  logic              mem_wea_o;
  logic [ADDR_W-1:0] mem_addra_o;
  logic [DATA_W-1:0] mem_dia_o;
  logic [DATA_W-1:0] mem_doa_i;

  logic [DATA_W-1:0] ram [0:255];
  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      exp_e;
  int                total = 0;
  int                bad = 0;
  int                cyc = 0;

  mem_blk_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_cea_o(mem_cea_o), .mem_wea_o(mem_wea_o), .mem_addra_o(mem_addra_o),
    .mem_dia_o(mem_dia_o), .mem_doa_i(mem_doa_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mem_blk port A model
  always @(posedge clk) begin
    if (mem_cea_o) begin
      if (mem_wea_o) ram[mem_addra_o] <= mem_dia_o;
      else           mem_doa_i <= ram[mem_addra_o];
    end
  end

  // driver: one cycle of stimulus, immediate grant/enable checks, expected response push
  task automatic drive(input logic r, input logic [1:0] req, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] eg, input logic ec, input logic push,
                       input logic ee, input logic [31:0] ed);
    @(posedge clk);
    #1;
    rst = r; req_i = req; we_i = we;
    addr0_i = a0; addr1_i = a1; wdata0_i = d0; wdata1_i = d1;
    @(negedge clk);
    total++;
    if (gnt_o !== eg) begin
      bad++;
      $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, gnt_o, eg);
    end
    total++;
    if (mem_cea_o !== ec) begin
      bad++;
      $display("FAIL cea cyc=%0d got=%b want=%b", cyc, mem_cea_o, ec);
    end
    if (push) exp_q.push_back({16'(cyc + 1), eg, ee, ed});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][W-1:W-16] < 16'(cyc)) begin
      exp_e = exp_q.pop_front();
      total++; bad++;
      $display("FAIL missed_resp cyc=%0d want_due=%0d", cyc, exp_e[W-1:W-16]);
    end
    if (exp_q.size() > 0 && exp_q[0][W-1:W-16] == 16'(cyc)) begin
      exp_e = exp_q.pop_front();
      total++;
      if ({rvalid_o, err_o, rdata_o} !== exp_e[W-17:0]) begin
        bad++;
        $display("FAIL resp cyc=%0d got rvalid=%b err=%b rdata=%h want rvalid=%b err=%b rdata=%h",
                 cyc, rvalid_o, err_o, rdata_o, exp_e[W-17:W-18], exp_e[DATA_W], exp_e[DATA_W-1:0]);
      end
    end else if (rvalid_o !== 2'b00 || err_o !== 1'b0) begin
      total++; bad++;
      $display("FAIL unexpected_resp cyc=%0d got rvalid=%b err=%b want rvalid=00 err=0",
               cyc, rvalid_o, err_o);
    end
  end

  initial begin
    rst = 1'b1; req_i = 2'b00; we_i = 2'b00;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;

    // reset held with both requesting
    repeat (3) drive(1, 2'b11, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0);
    // release: port 0 wins, writes 0x5555_5555 to 0x10
    drive(0, 2'b11, 2'b11, 8'h10, 8'h20, 32'h5555_5555, 32'h1234, 2'b01, 1, 1, 0, 0);
    // read back on port 0
    drive(0, 2'b01, 2'b00, 8'h10, 8'h20, 0, 0, 2'b01, 1, 1, 0, 32'h5555_5555);
    // preload 0x01=A1 (port 0) and 0x02=B2 (port 1)
    drive(0, 2'b01, 2'b01, 8'h01, 8'h02, 32'hA1, 0, 2'b01, 1, 1, 0, 0);
    drive(0, 2'b10, 2'b10, 8'h01, 8'h02, 0, 32'hB2, 2'b10, 1, 1, 0, 0);
    // contention: six cycles of dual reads
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b11, 2'b00, 8'h01, 8'h02, 0, 0, 2'b01, 1, 1, 0, 32'hA1);
      drive(0, 2'b11, 2'b00, 8'h01, 8'h02, 0, 0, 2'b10, 1, 1, 0, 32'hB2);
    end
    // out of range on port 1: 0xC8 read, 0xFF write; in-range 0xC7 write then read
    drive(0, 2'b10, 2'b00, 8'h00, 8'hC8, 0, 0, 2'b10, 0, 1, 1, 0);
    drive(0, 2'b10, 2'b10, 8'h00, 8'hFF, 0, 32'hDEAD, 2'b10, 0, 1, 1, 0);
    drive(0, 2'b10, 2'b10, 8'h00, 8'hC7, 0, 32'hC7C7, 2'b10, 1, 1, 0, 0);
    drive(0, 2'b10, 2'b00, 8'h00, 8'hC7, 0, 0, 2'b10, 1, 1, 0, 32'hC7C7);
    // idle priority retention: port 0 grant, idle 3, dual -> port 1
    drive(0, 2'b01, 2'b00, 8'h10, 8'h02, 0, 0, 2'b01, 1, 1, 0, 32'h5555_5555);
    repeat (3) drive(0, 2'b00, 2'b00, 8'h10, 8'h02, 0, 0, 2'b00, 0, 0, 0, 0);
    drive(0, 2'b11, 2'b00, 8'h10, 8'h02, 0, 0, 2'b10, 1, 1, 0, 32'hB2);
    // reset mid-operation: port-1 write in T, reset in T+1, response dropped
    drive(0, 2'b10, 2'b10, 8'h10, 8'h30, 0, 32'h77, 2'b10, 1, 0, 0, 0);
    drive(1, 2'b11, 2'b00, 8'h10, 8'h02, 0, 0, 2'b00, 0, 0, 0, 0);
    drive(0, 2'b11, 2'b00, 8'h10, 8'h02, 0, 0, 2'b01, 1, 1, 0, 32'h5555_5555);
    // port-0 grant leaves priority on port 1; reset must put it back on port 0
    drive(0, 2'b01, 2'b01, 8'h40, 8'h02, 32'h99, 0, 2'b01, 1, 0, 0, 0);
    drive(1, 2'b00, 2'b00, 8'h10, 8'h02, 0, 0, 2'b00, 0, 0, 0, 0);
    drive(0, 2'b11, 2'b00, 8'h40, 8'h02, 0, 0, 2'b01, 1, 1, 0, 32'h99);
    drive(0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
